// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM bus definitions: widths, refresh period, command encodings
// and the arbiter state type.
package sdram_arbiter_pkg;

  localparam int SDR_ASIZE      = 12;
  localparam int SDR_BSIZE      = 2;
  localparam int SDR_REF_PERIOD = 1560;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] SDR_CMD_NOP       = 4'b0111;
  localparam logic [3:0] SDR_CMD_ACT       = 4'b0011;
  localparam logic [3:0] SDR_CMD_READ      = 4'b0101;
  localparam logic [3:0] SDR_CMD_WRITE     = 4'b0100;
  localparam logic [3:0] SDR_CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] SDR_CMD_AREF      = 4'b0001;
  localparam logic [3:0] SDR_CMD_LMR       = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REFRESH,
    ST_WRITE,
    ST_READ
  } arb_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running auto-refresh period timer: raises ref_pending on every wrap
// and latches ref_missed when a wrap finds a refresh still outstanding.
module sdram_ref_timer
  import sdram_arbiter_pkg::*;
#(
  parameter int PERIOD = SDR_REF_PERIOD
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable_i,
  input  logic clear_i,
  output logic ref_pending_o,
  output logic ref_missed_o
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] count_q, count_d;
  logic          pending_q, pending_d;
  logic          missed_q, missed_d;
  logic          wrap;

  assign wrap = enable_i && (count_q == CW'(PERIOD - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q   <= '0;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
    end
  end

  // A wrap wins over a clear so a request arriving as refresh starts is kept.
  always_comb begin
    count_d   = count_q;
    pending_d = pending_q;
    missed_d  = missed_q;
    if (enable_i) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
    if (wrap) begin
      pending_d = 1'b1;
      missed_d  = missed_q | pending_q;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end
  end

  assign ref_pending_o = pending_q;
  assign ref_missed_o  = missed_q;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command bus sequencer: forwards SDRAM_init until init_done, then
// arbitrates refresh / write / read engines onto registered SDRAM pins.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int         ASIZE      = SDR_ASIZE,
  parameter int         BSIZE      = SDR_BSIZE,
  parameter int         REF_PERIOD = SDR_REF_PERIOD,
  parameter logic [3:0] CMD_NOP    = SDR_CMD_NOP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             init_done,
  input  logic [3:0]       init_command,
  input  logic [ASIZE-1:0] init_saddr,
  input  logic [3:0]       ref_command,
  input  logic [ASIZE-1:0] ref_saddr,
  output logic             ref_grant,
  input  logic             ref_done,
  input  logic             wr_req,
  input  logic [3:0]       wr_command,
  input  logic [ASIZE-1:0] wr_saddr,
  input  logic [BSIZE-1:0] wr_ba,
  output logic             wr_grant,
  input  logic             wr_done,
  input  logic             rd_req,
  input  logic [3:0]       rd_command,
  input  logic [ASIZE-1:0] rd_saddr,
  input  logic [BSIZE-1:0] rd_ba,
  output logic             rd_grant,
  input  logic             rd_done,
  output logic             ref_missed,
  output logic [3:0]       command,
  output logic [ASIZE-1:0] saddr,
  output logic [BSIZE-1:0] ba
);

  arb_state_e       state_q, state_d;
  logic             lastWasWrite_q, lastWasWrite_d;
  logic [3:0]       command_q, command_d;
  logic [ASIZE-1:0] saddr_q, saddr_d;
  logic [BSIZE-1:0] ba_q, ba_d;
  logic             refPending;
  logic             refEnter;
  logic             timerEnable;

  // Keeps counting once out of INIT even if init_done is later dropped.
  assign timerEnable = init_done || (state_q != ST_INIT);
  assign refEnter    = (state_q == ST_IDLE) && refPending;

  sdram_ref_timer #(
    .PERIOD(REF_PERIOD)
  ) u_ref_timer (
    .CLK          (CLK),
    .RST          (RST),
    .enable_i     (timerEnable),
    .clear_i      (refEnter),
    .ref_pending_o(refPending),
    .ref_missed_o (ref_missed)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= ST_INIT;
      lastWasWrite_q <= 1'b0;
      command_q      <= CMD_NOP;
      saddr_q        <= '0;
      ba_q           <= '0;
    end else begin
      state_q        <= state_d;
      lastWasWrite_q <= lastWasWrite_d;
      command_q      <= command_d;
      saddr_q        <= saddr_d;
      ba_q           <= ba_d;
    end
  end

  // Refresh beats both engines; between engines the one served last yields.
  always_comb begin
    state_d        = state_q;
    lastWasWrite_d = lastWasWrite_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (refPending) begin
          state_d = ST_REFRESH;
        end else if (wr_req && (!rd_req || !lastWasWrite_q)) begin
          state_d        = ST_WRITE;
          lastWasWrite_d = 1'b1;
        end else if (rd_req) begin
          state_d        = ST_READ;
          lastWasWrite_d = 1'b0;
        end
      end
      ST_REFRESH: begin
        if (ref_done) state_d = ST_IDLE;
      end
      ST_WRITE: begin
        if (wr_done) state_d = ST_IDLE;
      end
      ST_READ: begin
        if (rd_done) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    command_d = CMD_NOP;
    saddr_d   = saddr_q;
    ba_d      = ba_q;
    unique case (state_q)
      ST_INIT: begin
        command_d = init_command;
        saddr_d   = init_saddr;
        ba_d      = '0;
      end
      ST_REFRESH: begin
        command_d = ref_command;
        saddr_d   = ref_saddr;
        ba_d      = '0;
      end
      ST_WRITE: begin
        command_d = wr_command;
        saddr_d   = wr_saddr;
        ba_d      = wr_ba;
      end
      ST_READ: begin
        command_d = rd_command;
        saddr_d   = rd_saddr;
        ba_d      = rd_ba;
      end
      default: begin
        command_d = CMD_NOP;
      end
    endcase
  end

  assign ref_grant = (state_q == ST_REFRESH);
  assign wr_grant  = (state_q == ST_WRITE);
  assign rd_grant  = (state_q == ST_READ);
  assign command   = command_q;
  assign saddr     = saddr_q;
  assign ba        = ba_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed/randomised bench for sdram_arbiter: engine buses carry random
// values and refresh timing follows an arithmetic model of the period timer.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int AW     = SDR_ASIZE;
  localparam int BW     = SDR_BSIZE;
  localparam int PERIOD = SDR_REF_PERIOD;
  localparam int ENG_REF = 0;
  localparam int ENG_WR  = 1;
  localparam int ENG_RD  = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          init_done;
  logic [3:0]    init_command;
  logic [AW-1:0] init_saddr;
  logic [3:0]    ref_command;
  logic [AW-1:0] ref_saddr;
  logic          ref_grant;
  logic          ref_done;
  logic          wr_req, wr_grant, wr_done;
  logic [3:0]    wr_command;
  logic [AW-1:0] wr_saddr;
  logic [BW-1:0] wr_ba;
  logic          rd_req, rd_grant, rd_done;
  logic [3:0]    rd_command;
  logic [AW-1:0] rd_saddr;
  logic [BW-1:0] rd_ba;
  logic          ref_missed;
  logic [3:0]    command;
  logic [AW-1:0] saddr;
  logic [BW-1:0] ba;

  int assertCount  = 0;
  int failCount    = 0;
  int enCycles     = 0;
  bit counting     = 1'b0;
  bit modelPending = 1'b0;
  bit modelMissed  = 1'b0;

  always #5 CLK = ~CLK;

  sdram_arbiter dut (
    .CLK         (CLK),
    .RST         (RST),
    .init_done   (init_done),
    .init_command(init_command),
    .init_saddr  (init_saddr),
    .ref_command (ref_command),
    .ref_saddr   (ref_saddr),
    .ref_grant   (ref_grant),
    .ref_done    (ref_done),
    .wr_req      (wr_req),
    .wr_command  (wr_command),
    .wr_saddr    (wr_saddr),
    .wr_ba       (wr_ba),
    .wr_grant    (wr_grant),
    .wr_done     (wr_done),
    .rd_req      (rd_req),
    .rd_command  (rd_command),
    .rd_saddr    (rd_saddr),
    .rd_ba       (rd_ba),
    .rd_grant    (rd_grant),
    .rd_done     (rd_done),
    .ref_missed  (ref_missed),
    .command     (command),
    .saddr       (saddr),
    .ba          (ba)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; the refresh model counts enabled edges and wraps every PERIOD.
  task automatic tick;
    @(posedge CLK);
    #1;
    if (counting) begin
      enCycles++;
      if (enCycles % PERIOD == 0) begin
        if (modelPending) modelMissed = 1'b1;
        modelPending = 1'b1;
      end
    end
    checkOutput("ref_missed", {31'b0, ref_missed}, {31'b0, modelMissed});
  endtask

  task automatic applyStimulus(input int eng, output logic [3:0] c,
                               output logic [AW-1:0] a, output logic [BW-1:0] b);
    c = 4'($urandom);
    a = AW'($urandom);
    b = (eng == ENG_REF) ? '0 : BW'($urandom);
    case (eng)
      ENG_REF: begin ref_command = c; ref_saddr = a; end
      ENG_WR:  begin wr_command = c; wr_saddr = a; wr_ba = b; end
      default: begin rd_command = c; rd_saddr = a; rd_ba = b; end
    endcase
  endtask

  task automatic checkBus(input string tag, input logic [3:0] c,
                          input logic [AW-1:0] a, input logic [BW-1:0] b);
    checkOutput({tag, ".command"}, {28'b0, command}, {28'b0, c});
    checkOutput({tag, ".saddr"}, {20'b0, saddr}, {20'b0, a});
    checkOutput({tag, ".ba"}, {30'b0, ba}, {30'b0, b});
  endtask

  function automatic logic [31:0] grants();
    return {29'b0, ref_grant, wr_grant, rd_grant};
  endfunction

  initial begin
    logic [3:0]    c;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    bit            expRead;
    int            waitCnt;

    RST = 1'b1; init_done = 1'b0;
    init_command = SDR_CMD_NOP; init_saddr = '0;
    ref_command = SDR_CMD_NOP; ref_saddr = '0; ref_done = 1'b0;
    wr_req = 1'b0; wr_command = SDR_CMD_NOP; wr_saddr = '0; wr_ba = '0; wr_done = 1'b0;
    rd_req = 1'b0; rd_command = SDR_CMD_NOP; rd_saddr = '0; rd_ba = '0; rd_done = 1'b0;

    repeat (20) tick;
    checkBus("reset", SDR_CMD_NOP, '0, '0);
    checkOutput("reset.grants", grants(), 32'd0);
    RST = 1'b0;

    $display("[TB] init pass-through");
    for (int i = 0; i < 6; i++) begin
      c = 4'($urandom); a = AW'($urandom);
      init_command = c; init_saddr = a;
      tick;
      checkBus("init", c, a, '0);
    end
    c = 4'($urandom); a = AW'($urandom);
    init_command = c; init_saddr = a; init_done = 1'b1; counting = 1'b1;
    tick;
    checkBus("initLast", c, a, '0);
    tick;
    checkOutput("idle.command", {28'b0, command}, {28'b0, SDR_CMD_NOP});
    checkOutput("idle.grants", grants(), 32'd0);

    $display("[TB] single write");
    wr_req = 1'b1;
    tick;
    checkOutput("wr.grant", grants(), 32'b010);
    checkOutput("wr.firstNop", {28'b0, command}, {28'b0, SDR_CMD_NOP});
    wr_req = 1'b0;
    applyStimulus(ENG_WR, c, a, b);
    wr_command = SDR_CMD_WRITE; c = SDR_CMD_WRITE;
    tick;
    checkBus("wr.cmd0", c, a, b);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ENG_WR, c, a, b);
      tick;
      checkBus("wr.cmd", c, a, b);
      checkOutput("wr.held", grants(), 32'b010);
    end
    applyStimulus(ENG_WR, c, a, b);
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    checkOutput("wr.release", grants(), 32'd0);
    checkBus("wr.last", c, a, b);
    tick;
    checkOutput("wr.gapNop", {28'b0, command}, {28'b0, SDR_CMD_NOP});

    $display("[TB] round-robin alternation");
    wr_req = 1'b1; rd_req = 1'b1;
    expRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput("rr.grant", grants(), expRead ? 32'b001 : 32'b010);
      checkOutput("rr.gapNop", {28'b0, command}, {28'b0, SDR_CMD_NOP});
      applyStimulus(expRead ? ENG_RD : ENG_WR, c, a, b);
      if (expRead) wr_done = 1'b1; else rd_done = 1'b1;
      tick;
      wr_done = 1'b0; rd_done = 1'b0;
      checkOutput("rr.foreignDone", grants(), expRead ? 32'b001 : 32'b010);
      checkBus("rr.bus", c, a, b);
      applyStimulus(expRead ? ENG_RD : ENG_WR, c, a, b);
      if (expRead) rd_done = 1'b1; else wr_done = 1'b1;
      tick;
      wr_done = 1'b0; rd_done = 1'b0;
      checkOutput("rr.release", grants(), 32'd0);
      checkBus("rr.last", c, a, b);
      expRead = !expRead;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick;
    checkOutput("rr.idle", grants(), 32'd0);
    checkOutput("rr.idleNop", {28'b0, command}, {28'b0, SDR_CMD_NOP});

    $display("[TB] refresh waits for long write");
    wr_req = 1'b1;
    tick;
    checkOutput("long.grant", grants(), 32'b010);
    wr_req = 1'b0;
    while (enCycles < PERIOD + 40) begin
      applyStimulus(ENG_WR, c, a, b);
      if (enCycles == PERIOD + 10) rd_req = 1'b1;
      tick;
      checkOutput("long.command", {28'b0, command}, {28'b0, c});
    end
    checkOutput("long.noPreempt", grants(), 32'b010);
    applyStimulus(ENG_WR, c, a, b);
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    checkOutput("long.release", grants(), 32'd0);
    tick;
    checkOutput("ref.beforeRead", grants(), 32'b100);
    modelPending = 1'b0;
    a = AW'($urandom);
    ref_command = SDR_CMD_AREF; ref_saddr = a;
    tick;
    checkBus("ref.bus", SDR_CMD_AREF, a, '0);
    ref_done = 1'b1;
    tick;
    ref_done = 1'b0;
    checkOutput("ref.release", grants(), 32'd0);
    tick;
    checkOutput("rd.afterRef", grants(), 32'b001);
    rd_req = 1'b0;
    applyStimulus(ENG_RD, c, a, b);
    tick;
    checkBus("rd.bus", c, a, b);
    rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
    checkOutput("rd.release", grants(), 32'd0);

    $display("[TB] missed refresh");
    waitCnt = 0;
    while (!ref_grant && waitCnt < 2 * PERIOD) begin
      tick;
      waitCnt++;
    end
    checkOutput("ref2.grant", grants(), 32'b100);
    checkOutput("ref2.when", enCycles, 2 * PERIOD + 1);
    modelPending = 1'b0;
    while (enCycles < 4 * PERIOD + 5) tick;
    checkOutput("missed.set", {31'b0, ref_missed}, 32'd1);
    checkOutput("missed.stillRef", grants(), 32'b100);
    ref_done = 1'b1;
    tick;
    ref_done = 1'b0;
    checkOutput("missed.release", grants(), 32'd0);
    tick;
    checkOutput("ref3.grant", grants(), 32'b100);
    modelPending = 1'b0;
    ref_done = 1'b1;
    tick;
    ref_done = 1'b0;
    tick;
    checkOutput("missed.sticky", {31'b0, ref_missed}, 32'd1);

    $display("[TB] reset during read");
    rd_req = 1'b1;
    tick;
    checkOutput("rst.rdGrant", grants(), 32'b001);
    rd_req = 1'b0;
    applyStimulus(ENG_RD, c, a, b);
    tick;
    checkBus("rst.rdBus", c, a, b);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rst.grants", grants(), 32'd0);
    checkOutput("rst.command", {28'b0, command}, {28'b0, SDR_CMD_NOP});
    checkOutput("rst.missed", {31'b0, ref_missed}, 32'd0);
    counting = 1'b0; enCycles = 0; modelPending = 1'b0; modelMissed = 1'b0;
    init_done = 1'b0;
    tick;
    tick;
    RST = 1'b0;
    c = 4'($urandom); a = AW'($urandom);
    init_command = c; init_saddr = a;
    tick;
    checkBus("rst.backToInit", c, a, '0);
    checkOutput("rst.initGrants", grants(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
